fwd_hazard_ctrl: RTL and testbench

Forwarding and hazard control unit for the pipelined CPU datapath. It tracks the destination registers of the instructions in EX and MEM and generates the 2-bit select codes for the EX-stage operand three-way muxes: 0 = register file, 1 = EX/MEM ALU result, 2 = MEM/WB result. It also raises a load-use stall and counts stall cycles. It sits beside the ID/EX pipeline register and drives the operand-mux selects and the pipeline hold/bubble controls.

---
 rtl/fwd_hazard_ctrl.sv | 89 ++++++++
 tb/tb_fwd_hazard_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// EX-operand forwarding selects (registered, valid for the consumer's EX cycle) and load-use stall
// (combinational from ID and the EX entry); no backpressure other than the stall it raises.
module fwd_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic              flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [REG_AW-1:0] ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d;
  logic              ex_we_q, ex_we_d, ex_ld_q, ex_ld_d, mem_we_q, mem_we_d;
  logic [1:0]        fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
  logic [1:0] sel_a, sel_b;
  logic bubble;

  // r0 is hardwired zero, so a write to it is never a real producer
  assign ex_hit_rs  = id_rs_used && ex_we_q  && (ex_rd_q  != '0) && (ex_rd_q  == id_rs);
  assign ex_hit_rt  = id_rt_used && ex_we_q  && (ex_rd_q  != '0) && (ex_rd_q  == id_rt);
  assign mem_hit_rs = id_rs_used && mem_we_q && (mem_rd_q != '0) && (mem_rd_q == id_rs);
  assign mem_hit_rt = id_rt_used && mem_we_q && (mem_rd_q != '0) && (mem_rd_q == id_rt);

  assign sel_a = ex_hit_rs ? 2'd1 : (mem_hit_rs ? 2'd2 : 2'd0);
  assign sel_b = ex_hit_rt ? 2'd1 : (mem_hit_rt ? 2'd2 : 2'd0);

  assign stall  = !flush && ex_ld_q && (ex_hit_rs || ex_hit_rt);
  assign bubble = stall || flush;

  always_comb begin
    mem_rd_d    = ex_rd_q;
    mem_we_d    = ex_we_q;
    ex_rd_d     = id_rd;
    ex_we_d     = id_we;
    ex_ld_d     = id_is_load;
    fwd_a_d     = sel_a;
    fwd_b_d     = sel_b;
    stall_cnt_d = stall_cnt_q;
    if (bubble) begin
      ex_we_d = 1'b0;
      ex_ld_d = 1'b0;
      fwd_a_d = 2'd0;
      fwd_b_d = 2'd0;
    end
    if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd_q     <= '0;
      ex_we_q     <= 1'b0;
      ex_ld_q     <= 1'b0;
      mem_rd_q    <= '0;
      mem_we_q    <= 1'b0;
      fwd_a_q     <= 2'd0;
      fwd_b_q     <= 2'd0;
      stall_cnt_q <= '0;
    end else begin
      ex_rd_q     <= ex_rd_d;
      ex_we_q     <= ex_we_d;
      ex_ld_q     <= ex_ld_d;
      mem_rd_q    <= mem_rd_d;
      mem_we_q    <= mem_we_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench: per-cycle comparison against an instruction-age model plus literal spot checks.
module tb_fwd_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic       id_rs_used = 1'b0, id_rt_used = 1'b0, id_we = 1'b0, id_is_load = 1'b0, flush = 1'b0;
  logic [1:0] fwd_a_sel, fwd_b_sel, fwd_a_sel2, fwd_b_sel2;
  logic       stall, stall2;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt2;

  int n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used),
    .id_rt_used(id_rt_used), .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
    .flush(flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall),
    .stall_cnt(stall_cnt));

  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used),
    .id_rt_used(id_rt_used), .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
    .flush(flush), .fwd_a_sel(fwd_a_sel2), .fwd_b_sel(fwd_b_sel2), .stall(stall2),
    .stall_cnt(stall_cnt2));

  // Model: the instructions one and two ahead of the one in ID, by age.
  typedef struct packed {logic [4:0] rd; logic we; logic ld;} prod_t;
  prod_t age1, age2;
  logic [1:0] exp_a, exp_b;
  logic       exp_stall;
  int         exp_cnt;

  // Forwarding select equals the age of the youngest in-flight producer (max age 2).
  function automatic logic [1:0] nearest(prod_t p1, prod_t p2, logic [4:0] s, logic used);
    if (!used || s == 5'd0) return 2'd0;
    if (p1.we && p1.rd == s) return 2'd1;
    if (p2.we && p2.rd == s) return 2'd2;
    return 2'd0;
  endfunction

  always_comb begin
    exp_stall = 1'b0;
    if (!flush && age1.ld &&
        (nearest(age1, age2, id_rs, id_rs_used) == 2'd1 ||
         nearest(age1, age2, id_rt, id_rt_used) == 2'd1))
      exp_stall = 1'b1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age1 = '0; age2 = '0; exp_a = 2'd0; exp_b = 2'd0; exp_cnt = 0;
    end else begin
      logic kill;
      logic [1:0] na, nb;
      kill = exp_stall || flush;
      na = nearest(age1, age2, id_rs, id_rs_used);
      nb = nearest(age1, age2, id_rt, id_rt_used);
      if (exp_stall) exp_cnt = exp_cnt + 1;
      age2 = age1;
      age1 = kill ? prod_t'(0) : prod_t'({id_rd, id_we, id_is_load});
      exp_a = kill ? 2'd0 : na;
      exp_b = kill ? 2'd0 : nb;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison on the falling edge.
  always @(negedge clk) begin
    check("model_stall", int'(stall), int'(exp_stall));
    check("model_fwd_a", int'(fwd_a_sel), int'(exp_a));
    check("model_fwd_b", int'(fwd_b_sel), int'(exp_b));
    check("model_cnt", int'(stall_cnt), exp_cnt);
    check("model_cnt_sat", int'(stall_cnt2), (exp_cnt > 3) ? 3 : exp_cnt);
    check("model_stall_sat", int'(stall2), int'(exp_stall));
  end

  task automatic set_id(input logic [4:0] rd, input logic we, input logic ld,
                        input logic [4:0] rs, input logic rsu,
                        input logic [4:0] rt, input logic rtu, input logic fl);
    id_rd = rd; id_we = we; id_is_load = ld;
    id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu; flush = fl;
  endtask

  task automatic nop();
    set_id(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    nop();
    #3;
    check("reset_stall", int'(stall), 0);
    check("reset_fwd_a", int'(fwd_a_sel), 0);
    check("reset_cnt", int'(stall_cnt), 0);
    repeat (2) tick();
    rst_n = 1'b1;

    // Forward from EX
    set_id(5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); tick();
    set_id(5'd6, 1'b1, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0); #1;
    check("ex_fwd_no_stall", int'(stall), 0);
    tick();
    check("ex_fwd_a", int'(fwd_a_sel), 1);
    check("ex_fwd_b", int'(fwd_b_sel), 0);

    // Forward from MEM, then EX priority
    set_id(5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); tick();
    nop(); tick();
    set_id(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0); tick();
    check("mem_fwd_b", int'(fwd_b_sel), 2);
    set_id(5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); tick();
    tick();
    set_id(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0); tick();
    check("ex_priority_b", int'(fwd_b_sel), 1);

    // Load-use
    set_id(5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); tick();
    set_id(5'd8, 1'b1, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0); #1;
    check("lu_stall", int'(stall), 1);
    tick();
    check("lu_bubble_a", int'(fwd_a_sel), 0);
    check("lu_cnt", int'(stall_cnt), 1);
    #1 check("lu_stall_once", int'(stall), 0);
    tick();
    check("lu_fwd_a_mem", int'(fwd_a_sel), 2);

    // Register 0 and unused source
    set_id(5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); tick();
    set_id(5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0); tick();
    check("r0_a", int'(fwd_a_sel), 0);
    check("r0_b", int'(fwd_b_sel), 0);
    set_id(5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); tick();
    set_id(5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b0, 1'b0); #1;
    check("unused_rt_no_stall", int'(stall), 0);
    tick();

    // Flush beats stall
    set_id(5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); tick();
    set_id(5'd1, 1'b1, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1); #1;
    check("flush_no_stall", int'(stall), 0);
    tick();
    check("flush_cnt", int'(stall_cnt), 1);
    check("flush_bubble_a", int'(fwd_a_sel), 0);
    nop(); tick();

    // Four more load-use stalls; the 2-bit counter saturates
    for (int i = 0; i < 4; i++) begin
      set_id(5'd10, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); tick();
      set_id(5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0); tick();
      tick();
    end
    check("cnt_five", int'(stall_cnt), 5);
    check("cnt_saturated", int'(stall_cnt2), 3);

    // Both sources, different stages
    set_id(5'd11, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); tick();
    set_id(5'd12, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); tick();
    set_id(5'd0, 1'b0, 1'b0, 5'd11, 1'b1, 5'd12, 1'b1, 1'b0); tick();
    check("dual_a_mem", int'(fwd_a_sel), 2);
    check("dual_b_ex", int'(fwd_b_sel), 1);

    // Reset during a stall
    set_id(5'd13, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); tick();
    set_id(5'd14, 1'b1, 1'b0, 5'd13, 1'b1, 5'd0, 1'b0, 1'b0); #1;
    check("pre_reset_stall", int'(stall), 1);
    rst_n = 1'b0;
    #1;
    check("rst_stall", int'(stall), 0);
    check("rst_fwd_a", int'(fwd_a_sel), 0);
    check("rst_fwd_b", int'(fwd_b_sel), 0);
    check("rst_cnt", int'(stall_cnt), 0);
    tick(); tick();
    rst_n = 1'b1;
    set_id(5'd15, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); tick();
    set_id(5'd0, 1'b0, 1'b0, 5'd15, 1'b1, 5'd0, 1'b0, 1'b0); tick();
    check("post_reset_fwd_a", int'(fwd_a_sel), 1);
    nop(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
